cache_control_l2: RTL and testbench

Control FSM for the 2-way, 8-set L2 cache. Sits directly beside the two L2 cache ways: it consumes each way's `hit` and `dirty` and drives their `load_word`/`load_line` strobes. It also arbitrates line fills and dirty write-backs to physical memory, answers the L1-side request handshake, and keeps per-set LRU state.

---
 rtl/cache_control_l2.sv | 142 ++++++++++++++
 tb/tb_cache_control_l2.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_control_l2.sv
// Control FSM for the 2-way, 8-set L2 cache: hit handling, LRU, write-back/fill.
// Optional perf counters: define L2_PERF_CNT_EN.
module cache_control_l2 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_resp,
    input  logic [2:0]  set,
    input  logic        hit0,
    input  logic        hit1,
    input  logic        dirty0,
    input  logic        dirty1,
    output logic        load_word0,
    output logic        load_word1,
    output logic        load_line0,
    output logic        load_line1,
    output logic        way_sel,
    output logic        pmem_addr_sel,
    output logic        pmem_read,
    output logic        pmem_write,
    input  logic        pmem_resp,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [31:0] wb_count
);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] lru;
    logic       victim;

    logic req;
    logic hit;
    logic hit_way;
    logic victim_dirty;

    assign req          = mem_read | mem_write;
    assign hit          = hit0 | hit1;
    assign hit_way      = ~hit0;
    assign victim_dirty = lru[set] ? dirty1 : dirty0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next state and strobes; everything is held low while reset is asserted
    always_comb begin
        next_state    = state;
        mem_resp      = 1'b0;
        load_word0    = 1'b0;
        load_word1    = 1'b0;
        load_line0    = 1'b0;
        load_line1    = 1'b0;
        way_sel       = 1'b0;
        pmem_addr_sel = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        if (rst_n) begin
            unique case (state)
                IDLE: begin
                    if (req && hit) begin
                        mem_resp = 1'b1;
                        way_sel  = hit_way;
                        if (mem_write) begin
                            load_word0 = ~hit_way;
                            load_word1 = hit_way;
                        end
                    end else if (req) begin
                        next_state = victim_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    way_sel       = victim;
                    if (pmem_resp) next_state = ALLOCATE;
                end
                ALLOCATE: begin
                    pmem_read = 1'b1;
                    way_sel   = victim;
                    if (pmem_resp) begin
                        load_line0 = ~victim;
                        load_line1 = victim;
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // LRU update on hits; victim capture when a miss is first seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lru    <= '0;
            victim <= 1'b0;
        end else if (state == IDLE && req) begin
            if (hit) lru[set] <= ~hit_way;
            else     victim   <= lru[set];
        end
    end

`ifdef L2_PERF_CNT_EN
    logic [31:0] hit_q;
    logic [31:0] miss_q;
    logic [31:0] wb_q;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= '0;
            wb_q   <= '0;
        end else begin
            if (mem_resp && hit_q != '1)
                hit_q <= hit_q + 32'd1;
            if (state == IDLE && next_state != IDLE && miss_q != '1)
                miss_q <= miss_q + 32'd1;
            if (state == WRITEBACK && pmem_resp && wb_q != '1)
                wb_q <= wb_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign wb_count   = wb_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_cache_control_l2.sv
// Bench for cache_control_l2: directed scenarios plus random traffic
// against a transaction-level model of LRU, victim choice and latency.
module tb_cache_control_l2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, mem_resp;
    logic [2:0]  set;
    logic        hit0, hit1, dirty0, dirty1;
    logic        load_word0, load_word1, load_line0, load_line1;
    logic        way_sel, pmem_addr_sel, pmem_read, pmem_write, pmem_resp;
    logic [31:0] hit_count, miss_count, wb_count;

    int tests = 0;
    int fails = 0;

    // model state: per-set least-recently-used way and event tallies
    logic [7:0] m_lru;
    int m_hits, m_miss, m_wb;

    // {mem_resp, lw0, lw1, ll0, ll1, way_sel, addr_sel, pmem_read, pmem_write}
    logic [8:0] obs;
    assign obs = {mem_resp, load_word0, load_word1, load_line0, load_line1,
                  way_sel, pmem_addr_sel, pmem_read, pmem_write};

    cache_control_l2 dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .set(set), .hit0(hit0), .hit1(hit1), .dirty0(dirty0), .dirty1(dirty1),
        .load_word0(load_word0), .load_word1(load_word1),
        .load_line0(load_line0), .load_line1(load_line1),
        .way_sel(way_sel), .pmem_addr_sel(pmem_addr_sel),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        hit0      = 1'b0;
        hit1      = 1'b0;
        pmem_resp = 1'b0;
    endtask

    task automatic model_reset();
        m_lru  = '0;
        m_hits = 0;
        m_miss = 0;
        m_wb   = 0;
    endtask

    // kind: 0 read, 1 write, 2 read+write; hw: 0 way0, 1 way1, 2 both
    task automatic do_hit(input logic [2:0] s, input int kind, input int hw);
        logic way, wr;
        logic [8:0] exp;
        way       = (hw == 1);
        wr        = (kind != 0);
        set       = s;
        mem_read  = (kind != 1);
        mem_write = (kind != 0);
        hit0      = (hw != 1);
        hit1      = (hw != 0);
        dirty0    = 1'($urandom);
        dirty1    = 1'($urandom);
        pmem_resp = 1'($urandom);
        exp = {1'b1, wr & ~way, wr & way, 2'b00, way, 3'b000};
        @(negedge clk);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL hit set=%0d kind=%0d hw=%0d: got %b want %b",
                     s, kind, hw, obs, exp);
        end
        m_lru[s] = ~way;
        m_hits++;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic do_miss(input logic [2:0] s, input int kind,
                           input logic dirty, input int wb_lat,
                           input int al_lat, input logic drop);
        logic v, wr, last;
        logic [8:0] exp;
        v         = m_lru[s];
        wr        = (kind != 0);
        set       = s;
        mem_read  = (kind != 1);
        mem_write = (kind != 0);
        hit0      = 1'b0;
        hit1      = 1'b0;
        dirty0    = v ? 1'($urandom) : dirty;
        dirty1    = v ? dirty : 1'($urandom);
        pmem_resp = 1'($urandom);
        @(negedge clk);
        tests++;
        if (obs !== 9'b0) begin
            fails++;
            $display("FAIL miss_idle set=%0d: got %b want %b", s, obs, 9'b0);
        end
        m_miss++;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        if (dirty) begin
            for (int k = 0; k < wb_lat; k++) begin
                pmem_resp = (k == wb_lat - 1);
                exp = {5'b0, v, 1'b1, 1'b0, 1'b1};
                @(negedge clk);
                tests++;
                if (obs !== exp) begin
                    fails++;
                    $display("FAIL writeback set=%0d k=%0d: got %b want %b",
                             s, k, obs, exp);
                end
                @(posedge clk); #1;
            end
            m_wb++;
        end
        for (int k = 0; k < al_lat; k++) begin
            last      = (k == al_lat - 1);
            pmem_resp = last;
            if (drop) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
            exp = {3'b0, last & ~v, last & v, 1'b0, 1'b0, 1'b1, 1'b0};
            @(negedge clk);
            tests++;
            if ((obs & 9'h1F7) !== exp) begin
                fails++;
                $display("FAIL allocate set=%0d k=%0d: got %b want %b",
                         s, k, obs & 9'h1F7, exp);
            end
            @(posedge clk); #1;
        end
        pmem_resp = 1'b0;
        hit0      = ~v;
        hit1      = v;
        if (drop) exp = 9'b0;
        else      exp = {1'b1, wr & ~v, wr & v, 2'b00, v, 3'b000};
        @(negedge clk);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL post_fill set=%0d drop=%0d: got %b want %b",
                     s, drop, obs, exp);
        end
        if (!drop) begin
            m_lru[s] = ~v;
            m_hits++;
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_counters(input string tag);
        int eh, em, ew;
`ifdef L2_PERF_CNT_EN
        eh = m_hits; em = m_miss; ew = m_wb;
`else
        eh = 0; em = 0; ew = 0;
`endif
        tests++;
        if (hit_count !== 32'(eh) || miss_count !== 32'(em) ||
            wb_count !== 32'(ew)) begin
            fails++;
            $display("FAIL counters %s: got %0d/%0d/%0d want %0d/%0d/%0d",
                     tag, hit_count, miss_count, wb_count, eh, em, ew);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        idle_inputs();
        set       = 3'd0;
        dirty0    = 1'b1;
        dirty1    = 1'b1;
        mem_read  = 1'b1;
        hit0      = 1'b1;
        pmem_resp = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (obs !== 9'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b want %b", obs, 9'b0);
        end
        check_counters("reset");
        rst_n = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        do_miss(3'd0, 0, 1'b0, 1, 2, 1'b0);
    endtask

    task automatic test_clean_miss();
        do_miss(3'd3, 0, 1'b0, 1, 4, 1'b0);
        do_miss(3'd3, 0, 1'b0, 1, 2, 1'b0);
    endtask

    task automatic test_write_hit();
        do_hit(3'd2, 1, 1);
        do_miss(3'd2, 0, 1'b0, 1, 1, 1'b0);
        do_hit(3'd6, 2, 2);
        do_miss(3'd6, 1, 1'b1, 1, 1, 1'b0);
    endtask

    task automatic test_dirty_miss();
        do_miss(3'd5, 0, 1'b1, 3, 2, 1'b0);
        do_miss(3'd4, 1, 1'b0, 1, 3, 1'b1);
    endtask

    task automatic test_reset_mid_alloc();
        set       = 3'd1;
        mem_read  = 1'b1;
        hit0      = 1'b0;
        hit1      = 1'b0;
        dirty0    = 1'b0;
        dirty1    = 1'b0;
        pmem_resp = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (pmem_read !== 1'b1) begin
            fails++;
            $display("FAIL alloc_before_reset: got %b want 1", pmem_read);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (obs !== 9'b0) begin
            fails++;
            $display("FAIL async_reset_drop: got %b want %b", obs, 9'b0);
        end
        model_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b1;
        @(negedge clk);
        tests++;
        if (obs !== 9'b0) begin
            fails++;
            $display("FAIL idle_after_reset: got %b want %b", obs, 9'b0);
        end
        check_counters("after_mid_reset");
        @(posedge clk); #1;
        idle_inputs();
        do_miss(3'd1, 0, 1'b1, 1, 1, 1'b0);
    endtask

    task automatic test_perf_counters();
        pulse_reset();
        do_hit(3'd0, 0, 0);
        do_hit(3'd1, 1, 1);
        do_hit(3'd2, 0, 0);
        do_miss(3'd3, 0, 1'b0, 1, 2, 1'b0);
        do_miss(3'd4, 1, 1'b1, 2, 2, 1'b0);
        check_counters("3hit_2miss_1wb");
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 0)
                do_hit(3'($urandom_range(0, 7)), $urandom_range(0, 2),
                       $urandom_range(0, 2));
            else
                do_miss(3'($urandom_range(0, 7)), $urandom_range(0, 2),
                        1'($urandom), $urandom_range(1, 4),
                        $urandom_range(1, 4), $urandom_range(0, 7) == 0);
        end
        check_counters("random");
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_write_hit();
        test_dirty_miss();
        test_reset_mid_alloc();
        test_perf_counters();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
